// File: rtl/bip_control.sv
// Control FSM for the accumulator CPU: fetch, decode and execute, three clocks per instruction.
// Latency is 3 clk per instruction; en=0 stalls state/PC/IR and gates all strobes.
module bip_control #(
  parameter int PC_W    = 11,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    Addr_prog,
  output logic [PC_W-1:0]    Addr_data,
  output logic [1:0]         SelA,
  output logic               SelB,
  output logic               Op,
  output logic               WrAcc,
  output logic               WrRam,
  output logic               RdRam,
  output logic               halted
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [4:0] dec_opc;
  logic [4:0] ex_opc;
  logic       acc_wr;
  logic       ram_wr;
  logic       ram_rd;

  assign dec_opc = Instr[INSTR_W-1 -: 5];
  assign ex_opc  = ir_q[INSTR_W-1 -: 5];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (en) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          ir_d    = Instr;
          state_d = (dec_opc == OP_HLT) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Mux selects follow state even while stalled; only the strobes are gated by en.
  always_comb begin
    Addr_data = '0;
    SelA      = 2'd0;
    SelB      = 1'b0;
    Op        = 1'b0;
    acc_wr    = 1'b0;
    ram_wr    = 1'b0;
    ram_rd    = 1'b0;
    case (state_q)
      S_DECODE: begin
        Addr_data = Instr[PC_W-1:0];
        ram_rd    = (dec_opc == OP_LD) || (dec_opc == OP_ADD) || (dec_opc == OP_SUB);
      end
      S_EXEC: begin
        Addr_data = ir_q[PC_W-1:0];
        case (ex_opc)
          OP_STO:  ram_wr = 1'b1;
          OP_LD:   acc_wr = 1'b1;
          OP_LDI:  begin acc_wr = 1'b1; SelA = 2'd1; end
          OP_ADD:  begin acc_wr = 1'b1; SelA = 2'd2; end
          OP_ADDI: begin acc_wr = 1'b1; SelA = 2'd2; SelB = 1'b1; end
          OP_SUB:  begin acc_wr = 1'b1; SelA = 2'd2; Op = 1'b1; end
          OP_SUBI: begin acc_wr = 1'b1; SelA = 2'd2; SelB = 1'b1; Op = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Addr_prog = pc_q;
  assign WrAcc     = acc_wr & en;
  assign WrRam     = ram_wr & en;
  assign RdRam     = ram_rd & en;
  assign halted    = (state_q == S_HALT);

endmodule
